// File: rtl/fsm_out_wrmem_if.sv
// Port bundle for the output-side transfer controller: the actor token
// stream, the local memory write port and the shared port-selector handshake.
// The controller uses the master modport; the surrounding wrapper uses slave.
interface fsm_out_wrmem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    // port-selector handshake
    logic              selected;
    logic              portEn;
    logic              free;
    // actor output token stream
    logic              OUT_send;
    logic [DATA_W-1:0] OUT_data;
    logic              OUT_rdy;
    // local output memory write port
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  selected,
        input  OUT_send,
        input  OUT_data,
        output portEn,
        output free,
        output OUT_rdy,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output selected,
        output OUT_send,
        output OUT_data,
        input  portEn,
        input  free,
        input  OUT_rdy,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/fsm_out_wrmem.sv
// Output-side transfer controller: drains one actor output port into the
// local output memory in bursts of at most BURST words per selector grant,
// writing consecutive addresses from base and raising endsend after size
// words. Optional feature: define FSM_OUT_WRMEM_STATS_EN to add the nbursts
// output, which counts released grants since the last re-arm.
module fsm_out_wrmem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10,
    parameter int BURST  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  size,
    input  logic [ADDR_W-1:0] base,
    fsm_out_wrmem_if.master   bus,
    output logic              endsend
`ifdef FSM_OUT_WRMEM_STATS_EN
    ,
    output logic [CNT_W-1:0]  nbursts
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RECV = 2'd2,
        FREE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [CNT_W-1:0]  wcnt, wcnt_n;
    logic [CNT_W-1:0]  bcnt, bcnt_n;
    logic [CNT_W-1:0]  wcnt_inc, bcnt_inc;
    logic              endburst;
    logic              rdy;
    logic              acc;

    assign endsend  = (wcnt == size);
    assign endburst = (bcnt == BURST_C);
    assign wcnt_inc = wcnt + 1'b1;
    assign bcnt_inc = bcnt + 1'b1;

    // Ready only while receiving with room left in both the grant and the transfer.
    assign rdy = (state == RECV) && !endburst && !endsend;
    assign acc = bus.OUT_send && rdy;

    assign bus.OUT_rdy = rdy;
    assign bus.wr_en   = acc;
    assign bus.wr_addr = addr;
    assign bus.wr_data = bus.OUT_data;
    assign bus.portEn  = (state == IDLE) && !bus.selected;
    assign bus.free    = (state == FREE);

    // State and counter registers; reset returns to IDLE without a free pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            wcnt  <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_n;
            addr  <= addr_n;
            wcnt  <= wcnt_n;
            bcnt  <= bcnt_n;
        end
    end

    // Next-state and counter updates: re-arm in IDLE, count accepts in RECV.
    always_comb begin
        state_n = state;
        addr_n  = addr;
        wcnt_n  = wcnt;
        bcnt_n  = bcnt;
        case (state)
            IDLE: begin
                if (!start) begin
                    addr_n = base;
                    wcnt_n = '0;
                end else if (bus.selected && !endsend) begin
                    state_n = ARM;
                end
            end
            ARM: begin
                bcnt_n  = '0;
                state_n = RECV;
            end
            RECV: begin
                if (acc) begin
                    addr_n = addr + 1'b1;
                    wcnt_n = wcnt_inc;
                    bcnt_n = bcnt_inc;
                end
                // Leave on a source stall, a closed window, or the last word of
                // the grant/transfer being taken this cycle.
                if (!bus.OUT_send || !rdy ||
                    (acc && ((bcnt_inc == BURST_C) || (wcnt_inc == size)))) begin
                    state_n = FREE;
                end
            end
            FREE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef FSM_OUT_WRMEM_STATS_EN
    // Grant counter: cleared on re-arm, bumped once per released grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nbursts <= '0;
        end else if ((state == IDLE) && !start) begin
            nbursts <= '0;
        end else if (state == FREE) begin
            nbursts <= nbursts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fsm_out_wrmem.sv
// Bench for fsm_out_wrmem: a wide-address and a 4-bit-address instance share
// one stimulus; a transaction-level model (words stored, words in grant, base)
// predicts every output each cycle, and directed scenarios pin literal values.
`timescale 1ns/1ps
module tb_fsm_out_wrmem;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;
    localparam int BURST  = 16;
    localparam int AW_M   = 10;
    localparam int AW_W   = 4;
    localparam int P_IDLE = 0, P_ARM = 1, P_RECV = 2, P_FREE = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              selected = 1'b0;
    logic              out_send = 1'b0;
    logic [DATA_W-1:0] dpat = 32'hD000_0000;
    logic [DATA_W-1:0] out_data = 32'hD000_0000;
    logic [CNT_W-1:0]  size = '0;
    logic [AW_M-1:0]   base = '0;
    logic              endsend_m, endsend_w;

    fsm_out_wrmem_if #(.DATA_W(DATA_W), .ADDR_W(AW_M)) if_m ();
    fsm_out_wrmem_if #(.DATA_W(DATA_W), .ADDR_W(AW_W)) if_w ();

    assign if_m.selected = selected;
    assign if_m.OUT_send = out_send;
    assign if_m.OUT_data = out_data;
    assign if_w.selected = selected;
    assign if_w.OUT_send = out_send;
    assign if_w.OUT_data = out_data;

`ifdef FSM_OUT_WRMEM_STATS_EN
    logic [CNT_W-1:0] nb_m, nb_w;
`endif

    fsm_out_wrmem #(.DATA_W(DATA_W), .ADDR_W(AW_M), .CNT_W(CNT_W), .BURST(BURST)) u_dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .base(base),
        .bus(if_m.master), .endsend(endsend_m)
`ifdef FSM_OUT_WRMEM_STATS_EN
        , .nbursts(nb_m)
`endif
    );

    fsm_out_wrmem #(.DATA_W(DATA_W), .ADDR_W(AW_W), .CNT_W(CNT_W), .BURST(BURST)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .size(size), .base(base[AW_W-1:0]),
        .bus(if_w.master), .endsend(endsend_w)
`ifdef FSM_OUT_WRMEM_STATS_EN
        , .nbursts(nb_w)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model and logs
    int m_ph = P_IDLE;
    int m_words = 0;
    int m_inb = 0;
    int m_nb = 0;
    int m_base = 0;
    int tok_cnt = 0;
    int n_wr = 0;
    int n_free = 0;
    int g_cur = 0;
    int g_lens[$];
    int wr_log_m[$];
    int wr_log_w[$];
    logic [DATA_W-1:0] mem_m [1024];
    logic [DATA_W-1:0] mem_w [16];

    always @(negedge clk) begin : model_chk
        bit e_end, e_rdy, e_acc, e_pen, e_free;
        int e_am, e_aw;
        if (rst) begin
            m_ph = P_IDLE; m_words = 0; m_inb = 0; m_nb = 0; m_base = 0; g_cur = 0;
        end
        e_end  = (m_words == int'(size));
        e_rdy  = (m_ph == P_RECV) && (m_inb != BURST) && !e_end;
        e_acc  = e_rdy && out_send;
        e_pen  = (m_ph == P_IDLE) && !selected;
        e_free = (m_ph == P_FREE);
        e_am   = (m_base + m_words) % (1 << AW_M);
        e_aw   = (m_base + m_words) % (1 << AW_W);

        chk("OUT_rdy", if_m.OUT_rdy, e_rdy);
        chk("wr_en",   if_m.wr_en,   e_acc);
        chk("portEn",  if_m.portEn,  e_pen);
        chk("free",    if_m.free,    e_free);
        chk("endsend", endsend_m,    e_end);
        chk("wr_addr", if_m.wr_addr, e_am);
        chk("w_OUT_rdy", if_w.OUT_rdy, e_rdy);
        chk("w_wr_en",   if_w.wr_en,   e_acc);
        chk("w_free",    if_w.free,    e_free);
        chk("w_endsend", endsend_w,    e_end);
        chk("w_wr_addr", if_w.wr_addr, e_aw);
        if (e_acc) begin
            chk("wr_data",   if_m.wr_data, out_data);
            chk("w_wr_data", if_w.wr_data, out_data);
        end
`ifdef FSM_OUT_WRMEM_STATS_EN
        chk("nbursts",   nb_m, m_nb);
        chk("w_nbursts", nb_w, m_nb);
`endif

        if (if_m.wr_en) begin
            mem_m[if_m.wr_addr] = if_m.wr_data;
            wr_log_m.push_back(int'(if_m.wr_addr));
            n_wr++; g_cur++; tok_cnt++;
        end
        if (if_w.wr_en) begin
            mem_w[if_w.wr_addr] = if_w.wr_data;
            wr_log_w.push_back(int'(if_w.wr_addr));
        end
        if (if_m.free) begin
            n_free++;
            g_lens.push_back(g_cur);
            g_cur = 0;
        end

        if (!rst) begin
            case (m_ph)
                P_IDLE: begin
                    if (!start) begin
                        m_base = int'(base); m_words = 0; m_nb = 0;
                    end else if (selected && !e_end) begin
                        m_ph = P_ARM;
                    end
                end
                P_ARM: begin
                    m_inb = 0; m_ph = P_RECV;
                end
                P_RECV: begin
                    if (e_acc) begin
                        m_words++; m_inb++;
                    end
                    if (!out_send || !e_rdy ||
                        (e_acc && (m_inb == BURST || m_words == int'(size))))
                        m_ph = P_FREE;
                end
                default: begin
                    m_nb++; m_ph = P_IDLE;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        out_data = dpat + DATA_W'(tok_cnt);
    endtask

    task automatic setup(input int sz, input int bs, input int snd);
        start = 1'b0;
        size = CNT_W'(sz);
        base = AW_M'(bs);
        out_send = snd[0];
        dpat = 32'hD000_0000 - DATA_W'(tok_cnt);
        out_data = dpat + DATA_W'(tok_cnt);
        step(); step();
    endtask

    task automatic wait_end(input string nm, input int budget);
        int i;
        i = 0;
        while (!endsend_m && i < budget) begin
            step(); i++;
        end
        chk({nm, " endsend reached"}, endsend_m, 1);
        repeat (3) step();
    endtask

    int w0, f0, w1, i;

    initial begin
        // reset state
        #7;
        chk("reset OUT_rdy", if_m.OUT_rdy, 0);
        chk("reset wr_en",   if_m.wr_en,   0);
        chk("reset free",    if_m.free,    0);
        chk("reset portEn",  if_m.portEn,  1);
        chk("reset wr_addr", if_m.wr_addr, 0);
        step(); step();
        rst = 1'b0;
        selected = 1'b1;

        // basic burst
        setup(4, 'h10, 1);
        w0 = n_wr; f0 = n_free;
        start = 1'b1;
        wait_end("basic", 40);
        chk("basic writes", n_wr - w0, 4);
        chk("basic frees", n_free - f0, 1);
        for (int k = 0; k < 4; k++) begin
            chk("basic addr", wr_log_m[w0 + k], 'h10 + k);
            chk("basic data", mem_m['h10 + k], 32'hD000_0000 + k);
        end

        // burst limit
        setup(40, 'h100, 1);
        w0 = n_wr; f0 = n_free;
        start = 1'b1;
        wait_end("burst", 200);
        chk("burst writes", n_wr - w0, 40);
        chk("burst frees", n_free - f0, 3);
        chk("burst grant0", g_lens[g_lens.size() - 3], 16);
        chk("burst grant1", g_lens[g_lens.size() - 2], 16);
        chk("burst grant2", g_lens[g_lens.size() - 1], 8);
        chk("burst last addr", wr_log_m[wr_log_m.size() - 1], 'h127);
        chk("burst last wrap addr", wr_log_w[wr_log_w.size() - 1], 7);
        chk("burst model words", m_words, 40);
`ifdef FSM_OUT_WRMEM_STATS_EN
        chk("burst nbursts", nb_m, 3);
`endif

        // source stall
        setup(8, 'h40, 1);
        w0 = n_wr; f0 = n_free;
        start = 1'b1;
        i = 0;
        while ((n_wr - w0) < 3 && i < 30) begin step(); i++; end
        chk("stall 3 words seen", n_wr - w0, 3);
        out_send = 1'b0;
        step();
        chk("stall free", if_m.free, 1);
        selected = 1'b0;
        step();
        chk("stall portEn", if_m.portEn, 1);
        step(); step();
        selected = 1'b1;
        out_send = 1'b1;
        wait_end("stall", 60);
        chk("stall writes", n_wr - w0, 8);
        chk("stall frees", n_free - f0, 2);
        chk("stall resume addr", wr_log_m[w0 + 3], 'h43);
        chk("stall resume data", mem_m['h43], 32'hD000_0003);

        // zero size
        setup(0, 'h80, 1);
        w0 = n_wr; f0 = n_free;
        start = 1'b1;
        repeat (10) step();
        chk("zero writes", n_wr - w0, 0);
        chk("zero frees", n_free - f0, 0);
        chk("zero endsend", endsend_m, 1);
        chk("zero portEn", if_m.portEn, 0);

        // reset mid-operation
        setup(10, 'h200, 1);
        w0 = n_wr;
        start = 1'b1;
        i = 0;
        while ((n_wr - w0) < 4 && i < 30) begin step(); i++; end
        chk("rst 4 words seen", n_wr - w0, 4);
        chk("rst 5th accept live", if_m.wr_en, 1);
        #2 rst = 1'b1;
        start = 1'b0;
        #1;
        chk("rst OUT_rdy", if_m.OUT_rdy, 0);
        chk("rst wr_en",   if_m.wr_en,   0);
        chk("rst free",    if_m.free,    0);
        chk("rst wr_addr", if_m.wr_addr, 0);
        chk("rst portEn",  if_m.portEn,  0);
        chk("rst endsend", endsend_m,    0);
`ifdef FSM_OUT_WRMEM_STATS_EN
        chk("rst nbursts", nb_m, 0);
`endif
        step(); step();
        rst = 1'b0;
        step(); step();
        w1 = n_wr; f0 = n_free;
        start = 1'b1;
        wait_end("rst", 60);
        chk("rst restart addr", wr_log_m[w1], 'h200);
        chk("rst rewrites", n_wr - w1, 10);
        chk("rst frees", n_free - f0, 1);

        // address wrap on the narrow instance
        setup(4, 'h00E, 1);
        w0 = wr_log_w.size();
        start = 1'b1;
        wait_end("wrap", 40);
        chk("wrap addr0", wr_log_w[w0 + 0], 'hE);
        chk("wrap addr1", wr_log_w[w0 + 1], 'hF);
        chk("wrap addr2", wr_log_w[w0 + 2], 'h0);
        chk("wrap addr3", wr_log_w[w0 + 3], 'h1);
        chk("wrap data0", mem_w['hE], 32'hD000_0000);
        chk("wrap data3", mem_w['h1], 32'hD000_0003);

        // randomized transfers
        for (int t = 0; t < 8; t++) begin
            setup(int'($urandom_range(1, 50)), int'($urandom_range(0, 1023)), 1);
            dpat = $urandom;
            start = 1'b1;
            i = 0;
            while (!endsend_m && i < 800) begin
                out_send = (($urandom % 10) < 7);
                selected = (($urandom % 4) != 0);
                start    = (($urandom % 60) != 0);
                step();
                i++;
            end
            start = 1'b1;
            selected = 1'b1;
            chk("random endsend reached", endsend_m, 1);
            repeat (3) step();
            chk("random model words", m_words, int'(size));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
